if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the single-cycle PC/IF_ID pair with a decoupled fetch engine. The engine issues requests to a variable-latency instruction memory over a request/grant/response handshake and buffers returned instructions in a FIFO of configurable depth. It presents them to ID through an IF/ID output register that honours the hazard stall and the EX/MEM branch redirect.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h00000000, PC value after reset (XLEN bits)
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥ 2
- PC_STEP, 4, PC increment per fetched instruction

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk
- hazard  in  1  ID stall; 1 holds IF/ID register and blocks queue pop
- redirect_valid  in  1  EX/MEM branch/jump taken (replaces EX_MEM_select)
- redirect_pc  in  XLEN  redirect target (replaces EX_MEM_newPC)
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PC)
- imem_gnt  in  1  memory accepts request this cycle (imem_req & imem_gnt = issue)
- imem_rvalid  in  1  response valid, in issue order, ≥ 1 cycle after issue
- imem_rdata  in  32  instruction word
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  XLEN  address of id_instr
- id_pc_next  out  XLEN  id_pc + PC_STEP
- fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy

## Operation
- State: pc, rsp_pc, outstanding counter (0..FQ_DEPTH), drop counter (0..FQ_DEPTH), FIFO of {instr, pc}, IF/ID register.
- Credit rule: imem_req = reset & ~redirect_valid & (outstanding + fq_count < FQ_DEPTH). The queue can therefore never overflow.
- Issue: pc += PC_STEP (mod 2^XLEN); outstanding += 1.
- Response: outstanding -= 1. If drop > 0, drop -= 1 and the word is discarded. Otherwise push {imem_rdata, rsp_pc}, then rsp_pc += PC_STEP.
- Issue and response in the same cycle: outstanding unchanged.
- Pop when hazard = 0 and queue non-empty. Push and pop in the same cycle are both allowed, including when the queue is full (credit rule makes the full+push case unreachable).
- IF/ID load when hazard = 0:
  - Queue non-empty: IF/ID <= head, id_valid = 1.
  - Queue empty: id_valid = 0, id_instr = 0 (NOP).
- hazard = 1: IF/ID and queue head hold; fetch continues while credits remain.
- Redirect (priority over hazard and over issue/response handling):
  - Next cycle: pc = rsp_pc = redirect_pc.
  - Queue is cleared and id_valid = 0.
  - drop = outstanding − (imem_rvalid this cycle ? 1 : 0), so a response arriving in the redirect cycle is discarded and responses still in flight are discarded.
  - No issue occurs in the redirect cycle.
- Back-to-back redirects: the latest wins. drop is recomputed from the current outstanding count.

## Timing
- Reset (reset = 0 at an edge) sets:
  - pc = rsp_pc = RESET_PC
  - outstanding = drop = 0, queue empty, fq_count = 0
  - id_valid = 0, id_instr = 0, id_pc = 0, id_pc_next = 0
- imem_req = 0 while reset = 0.
- Reset asserted mid-operation clears all state in one cycle. Responses arriving after reset is released are not tracked and must not occur; the memory is reset with the core.
- Minimum latency, redirect to id_valid: 1 cycle issue, then ≥ 1 cycle memory, then 1 cycle queue, then 1 cycle IF/ID. This gives 4 cycles with a 1-cycle memory.
- Steady state, single-cycle memory with gnt = 1: one instruction per cycle into ID.
- imem_addr valid only while imem_req = 1.
- All outputs are registered except imem_req/imem_addr, which are derived from registered state and redirect_valid.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release. Required: id_valid = 0; then the first imem_addr = RESET_PC = 0. Memory returns words 0xA, 0xB, 0xC at 1-cycle latency; ID then sees id_pc 0, 4, 8 with id_pc_next 4, 8, 12 on consecutive cycles.
- Hazard: hazard = 1 for 6 cycles mid-stream with FQ_DEPTH = 4. Required: IF/ID holds its instruction; fq_count saturates at 4; imem_req = 0 at full credit. After release, the next four id_pc values are consecutive with no loss or duplication.
- Redirect with in-flight fetches: memory latency 3 with 2 outstanding, then redirect_valid = 1 to 0x100. Required: both stale responses are dropped, queue flushed, id_valid = 0 next cycle. The next imem_addr is 0x100, and the first valid id_pc is 0x100.
- Redirect colliding with a response and with hazard = 1 in the same cycle. Required: the response is dropped; redirect is applied despite hazard; drop equals the remaining outstanding count.
- Grant backpressure: imem_gnt toggles every other cycle. Required: pc advances only on issue cycles, addresses remain sequential, and the instruction order into ID is preserved.
- PC wrap: RESET_PC = 0xFFFFFFF8. Required: issued addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory handshake and IF/ID output bundle of the decoupled fetch stage.
interface if_fetch_queue_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_next;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled fetch engine: credit-limited requests to a variable-latency memory, response FIFO,
// and an IF/ID register honouring hazard stalls and EX/MEM redirects.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hazard,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    if_fetch_queue_if.master          bus,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int unsigned     PtrW  = $clog2(FQ_DEPTH);
    localparam int unsigned     CntW  = PtrW + 1;
    localparam logic [XLEN-1:0] Step  = XLEN'(PC_STEP);
    localparam logic [CntW:0]   Depth = (CntW + 1)'(FQ_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]     fifo_instr_q [FQ_DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [FQ_DEPTH];
    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d, id_pc_next_q, id_pc_next_d;
    logic            credit_ok, req, issue, push, pop;

    // Outstanding requests reserve queue slots, so a response always finds room.
    assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < Depth;
    assign req       = reset & ~redirect_valid & credit_ok;
    assign issue     = req & bus.imem_gnt;

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.id_valid   = id_valid_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_pc_next = id_pc_next_q;
    assign fq_count       = cnt_q;

    always_comb begin
        pc_d         = pc_q;
        rsp_pc_d     = rsp_pc_q;
        out_d        = out_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the wrong path.
            pc_d       = redirect_pc;
            rsp_pc_d   = redirect_pc;
            out_d      = out_q - CntW'(bus.imem_rvalid);
            drop_d     = out_d;
            cnt_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            id_valid_d = 1'b0;
            id_instr_d = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + Step;
            end
            out_d = out_q + CntW'(issue) - CntW'(bus.imem_rvalid);
            if (bus.imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CntW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + Step;
                end
            end
            pop = ~hazard & (cnt_q != '0);
            if (!hazard) begin
                if (pop) begin
                    id_valid_d   = 1'b1;
                    id_instr_d   = fifo_instr_q[rptr_q];
                    id_pc_d      = fifo_pc_q[rptr_q];
                    id_pc_next_d = fifo_pc_q[rptr_q] + Step;
                end else begin
                    id_valid_d = 1'b0;
                    id_instr_d = '0;
                end
            end
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            out_q        <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
        end else begin
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wptr_q] <= bus.imem_rdata;
            fifo_pc_q[wptr_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue against a queue-based reference model and in-order memory.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hazard = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  fq_count;
    logic [2:0]  fq_count2;

    if_fetch_queue_if #(.XLEN(32)) u_bus ();
    if_fetch_queue_if #(.XLEN(32)) u_bus2 ();

    if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH), .PC_STEP(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .hazard         (hazard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (u_bus),
        .fq_count       (fq_count)
    );

    // Second instance only exercises address wrap; its memory never answers.
    if_fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(DEPTH), .PC_STEP(4)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .hazard         (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .bus            (u_bus2),
        .fq_count       (fq_count2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) + 32'hA;
    endfunction

    // In-order memory with configurable latency.
    int          lat = 1;
    int          cyc = 0;
    int          mem_last = -1;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // Reference model state.
    logic [31:0] m_pc = 32'h0, m_rsp = 32'h0;
    int          m_out = 0, m_drop = 0;
    logic [31:0] mq[$];
    logic        m_idv = 1'b0;
    logic [31:0] m_idpc = '0, m_idpcn = '0;
    logic        m_nop = 1'b1, m_zero = 1'b1;
    int          w_n = 0, w_seen = 0;

    function automatic logic mem_rv_next();
        return mem_due_q.size() > 0 && mem_due_q[0] <= cyc;
    endfunction

    task automatic step(input logic rst, input logic hz, input logic rv, input logic [31:0] rpc,
                        input logic gnt);
        logic        mrv, exp_req, dut_iss, w_req;
        logic [31:0] dut_addr, h;
        int          due;
        @(negedge clk);
        mrv = rst && mem_rv_next();
        reset             = rst;
        hazard            = hz;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        u_bus.imem_gnt    = gnt;
        u_bus.imem_rvalid = mrv;
        u_bus.imem_rdata  = mrv ? rom(mem_addr_q[0]) : 32'h0;
        u_bus2.imem_gnt    = 1'b1;
        u_bus2.imem_rvalid = 1'b0;
        u_bus2.imem_rdata  = 32'h0;
        #1;
        exp_req = rst && !rv && (m_out + mq.size() < DEPTH);
        check_eq("imem_req", {31'h0, u_bus.imem_req}, {31'h0, exp_req});
        if (exp_req) check_eq("imem_addr", u_bus.imem_addr, m_pc);
        dut_iss  = u_bus.imem_req && gnt;
        dut_addr = u_bus.imem_addr;
        w_req    = u_bus2.imem_req;
        if (w_req) check_eq("wrap_addr", u_bus2.imem_addr, 32'hFFFF_FFF8 + 32'(4 * w_n));
        @(posedge clk);
        // Memory side.
        if (!rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            mem_last = -1;
            w_n = 0;
        end else begin
            if (mrv) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (dut_iss) begin
                due = (cyc + lat > mem_last + 1) ? cyc + lat : mem_last + 1;
                mem_last = due;
                mem_addr_q.push_back(dut_addr);
                mem_due_q.push_back(due);
            end
            if (w_req) begin
                w_n++;
                w_seen++;
            end
        end
        cyc++;
        // Reference model.
        m_nop  = 1'b0;
        m_zero = 1'b0;
        if (!rst) begin
            m_pc = 32'h0; m_rsp = 32'h0; m_out = 0; m_drop = 0; mq.delete();
            m_idv = 1'b0; m_idpc = '0; m_idpcn = '0; m_nop = 1'b1; m_zero = 1'b1;
        end else if (rv) begin
            m_out  = m_out - (mrv ? 1 : 0);
            m_drop = m_out;
            m_pc   = rpc;
            m_rsp  = rpc;
            mq.delete();
            m_idv  = 1'b0;
        end else begin
            if (exp_req && gnt) m_pc = m_pc + 4;
            m_out = m_out + ((exp_req && gnt) ? 1 : 0) - (mrv ? 1 : 0);
            if (!hz) begin
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    m_idv = 1'b1; m_idpc = h; m_idpcn = h + 4;
                end else begin
                    m_idv = 1'b0; m_nop = 1'b1;
                end
            end
            if (mrv) begin
                if (m_drop > 0) m_drop--;
                else begin
                    mq.push_back(m_rsp);
                    m_rsp = m_rsp + 4;
                end
            end
        end
        #1;
        check_eq("id_valid", {31'h0, u_bus.id_valid}, {31'h0, m_idv});
        check_eq("fq_count", {29'h0, fq_count}, 32'(mq.size()));
        if (m_idv) begin
            check_eq("id_pc", u_bus.id_pc, m_idpc);
            check_eq("id_pc_next", u_bus.id_pc_next, m_idpcn);
            check_eq("id_instr", u_bus.id_instr, rom(m_idpc));
        end
        if (m_nop) check_eq("id_instr_nop", u_bus.id_instr, 32'h0);
        if (m_zero) begin
            check_eq("rst_id_pc", u_bus.id_pc, 32'h0);
            check_eq("rst_id_pc_next", u_bus.id_pc_next, 32'h0);
        end
    endtask

    initial begin
        logic        r, hz, rv, g;
        logic [31:0] rpc;
        int          k;
        u_bus.imem_gnt = 1'b0; u_bus.imem_rvalid = 1'b0; u_bus.imem_rdata = '0;
        u_bus2.imem_gnt = 1'b0; u_bus2.imem_rvalid = 1'b0; u_bus2.imem_rdata = '0;

        // Reset, then sequential stream at 1-cycle latency.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Six-cycle hazard: queue fills, credits run out.
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("hz_fq_full", {29'h0, fq_count}, 32'(DEPTH));
        check_eq("hz_req_blocked", {31'h0, u_bus.imem_req}, 32'h0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with two fetches in flight at latency 3.
        lat = 3;
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        for (k = 0; k < 20 && m_out != 2; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("redir_two_inflight", 32'(m_out), 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        check_eq("redir_idv_clear", {31'h0, u_bus.id_valid}, 32'h0);
        for (k = 0; k < 30; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (u_bus.id_valid) break;
        end
        check_eq("redir_first_valid", {31'h0, u_bus.id_valid}, 32'h1);
        check_eq("redir_first_pc", u_bus.id_pc, 32'h100);

        // Redirect colliding with a response while hazard is high.
        lat = 2;
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (k = 0; k < 20 && !mem_rv_next(); k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
        check_eq("coll_idv_clear", {31'h0, u_bus.id_valid}, 32'h0);
        for (k = 0; k < 30; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (u_bus.id_valid) break;
        end
        check_eq("coll_first_pc", u_bus.id_pc, 32'h300);

        // Grant toggling every other cycle.
        lat = 1;
        for (k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0, 32'h0, k[0]);

        // Randomised traffic with varying latency, stalls, redirects and resets.
        for (k = 0; k < 1500; k++) begin
            if (k % 100 == 0) lat = $urandom_range(1, 4);
            r   = ($urandom_range(0, 199) != 0);
            hz  = ($urandom_range(0, 99) < 30);
            rv  = ($urandom_range(0, 99) < 3);
            g   = ($urandom_range(0, 99) < 70);
            rpc = $urandom & 32'hFFFF_FFFC;
            step(r, hz, rv, rpc, g);
        end

        check_eq("wrap_issues_seen", {31'h0, (w_seen >= 3)}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
